// File: rtl/serial_comp_pkg.sv
// serial_comp_pkg: FSM states and result codes shared by the serial comparator.
package serial_comp_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [1:0] RES_EQ = 2'd0;
    localparam logic [1:0] RES_GR = 2'd1;
    localparam logic [1:0] RES_LT = 2'd2;
endpackage

// File: rtl/serial_comp_fsm_bit_cmp_cell.sv
// bit_cmp_cell: combinational single-bit magnitude compare.
module bit_cmp_cell (
    input  logic a_bit,
    input  logic b_bit,
    output logic bit_eq,
    output logic bit_gr,
    output logic bit_lt
);
    assign bit_eq = a_bit == b_bit;
    assign bit_gr = a_bit & ~b_bit;
    assign bit_lt = ~a_bit & b_bit;
endmodule

// File: rtl/serial_comp_fsm.sv
// serial_comp_fsm: MSB-first bit-serial unsigned comparator; SERIAL_COMP_EARLY_EXIT_EN stops at the first differing bit.
module serial_comp_fsm
    import serial_comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             gr,
    output logic             less
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t state, state_nx;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0] cnt;
    logic [1:0] res;
    logic bit_eq, bit_gr, bit_lt, accept, first_diff, stop;
    bit_cmp_cell u_cell (
        .a_bit (sa[WIDTH-1]),
        .b_bit (sb[WIDTH-1]),
        .bit_eq(bit_eq),
        .bit_gr(bit_gr),
        .bit_lt(bit_lt)
    );
    assign accept     = in_valid && in_ready;
    assign first_diff = (res == RES_EQ) && !bit_eq;
`ifdef SERIAL_COMP_EARLY_EXIT_EN
    assign stop = (cnt == CW'(1)) || first_diff;
`else
    assign stop = cnt == CW'(1);
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        state_nx  = state == IDLE ? (in_valid ? RUN : IDLE)
                  : state == RUN  ? (stop ? DONE : RUN)
                  : (out_ready ? IDLE : DONE);
        eq        = out_valid && res == RES_EQ;
        gr        = out_valid && res == RES_GR;
        less      = out_valid && res == RES_LT;
    end
    // Operands shift left so the cell always sees the current MSB-first pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa  <= '0;
            sb  <= '0;
            cnt <= '0;
            res <= RES_EQ;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            cnt <= CW'(WIDTH);
            res <= RES_EQ;
        end else if (state == RUN) begin
            sa  <= sa << 1;
            sb  <= sb << 1;
            cnt <= cnt == '0 ? '0 : cnt - CW'(1);
            if (first_diff) res <= bit_gr ? RES_GR : RES_LT;
        end
    end
endmodule

// File: tb/tb_serial_comp_fsm.sv
// tb_serial_comp_fsm: randomized and directed checks of serial_comp_fsm against a behavioural model.
module tb_serial_comp_fsm;
    localparam int WIDTH = 8;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic in_ready, out_valid, eq, gr, less;
    int tests = 0, fails = 0;

    serial_comp_fsm #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .eq(eq), .gr(gr), .less(less)
    );

    always #5 clk = ~clk;

    function automatic int model_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return x == y ? 0 : (x > y ? 1 : 2);
    endfunction

    // Cycles from the accept cycle to the first cycle showing out_valid.
    function automatic int model_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef SERIAL_COMP_EARLY_EXIT_EN
        for (int i = 0; i < WIDTH; i++)
            if (x[WIDTH-1-i] != y[WIDTH-1-i]) return i + 2;
`endif
        return WIDTH + 1;
    endfunction

    function automatic int obs_res();
        return ( eq && !gr && !less) ? 0 :
               (!eq &&  gr && !less) ? 1 :
               (!eq && !gr &&  less) ? 2 : -1;
    endfunction

    task automatic txn(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit keep,
                       output int lat, output int r);
        a = x; b = y; in_valid = 1'b1; lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!keep) in_valid = 1'b0;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
        end while (!out_valid && lat < 200);
        r = obs_res();
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({out_valid, eq, gr, less} !== 4'b0) begin
            fails++; $display("FAIL reset_outputs: got %b want 0000", {out_valid, eq, gr, less});
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_ready: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] da [6] = '{8'hA5, 8'h80, 8'h00, 8'hFF, 8'h7F, 8'h00};
        logic [WIDTH-1:0] db [6] = '{8'hA5, 8'h7F, 8'h01, 8'hFE, 8'h80, 8'h00};
        int lat, r;
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (in_ready !== 1'b1) begin
                fails++; $display("FAIL dir_ready[%0d]: got %b want 1", i, in_ready);
            end
            txn(da[i], db[i], 1'b0, lat, r);
            tests++;
            if (lat !== model_lat(da[i], db[i])) begin
                fails++; $display("FAIL dir_lat[%0d]: got %0d want %0d", i, lat, model_lat(da[i], db[i]));
            end
            tests++;
            if (r !== model_res(da[i], db[i])) begin
                fails++; $display("FAIL dir_res[%0d]: got %0d want %0d", i, r, model_res(da[i], db[i]));
            end
            @(negedge clk);
            tests++;
            if ({out_valid, eq, gr, less, in_ready} !== 5'b00001) begin
                fails++; $display("FAIL dir_idle[%0d]: got %b want 00001", i, {out_valid, eq, gr, less, in_ready});
            end
        end
    endtask

    task automatic test_mid_run();
        int n = 0;
        a = 8'h3C; b = 8'h3C; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({in_ready, out_valid, eq, gr, less} !== 5'b0) begin
            fails++; $display("FAIL run_outputs: got %b want 00000", {in_ready, out_valid, eq, gr, less});
        end
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
    endtask

    task automatic test_hold();
        int lat, r;
        out_ready = 1'b0;
        txn(8'h5A, 8'h3C, 1'b0, lat, r);
        tests++;
        if (r !== 1 || lat !== model_lat(8'h5A, 8'h3C)) begin
            fails++; $display("FAIL hold_first: res=%0d lat=%0d want 1 %0d", r, lat, model_lat(8'h5A, 8'h3C));
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 8'h00; b = 8'hFF;
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs_res() !== 1) begin
                fails++; $display("FAIL hold[%0d]: out_valid=%b in_ready=%b res=%0d want 1 0 1", i, out_valid, in_ready, obs_res());
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL hold_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL hold_ignored: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_abort();
        int seen = 0, lat, r;
        a = 8'h12; b = 8'h34; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL abort_idle: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++; $display("FAIL abort_no_valid: got %0d valid cycles want 0", seen);
        end
        txn(8'h10, 8'h20, 1'b0, lat, r);
        tests++;
        if (r !== 2 || lat !== model_lat(8'h10, 8'h20)) begin
            fails++; $display("FAIL abort_next: res=%0d lat=%0d want 2 %0d", r, lat, model_lat(8'h10, 8'h20));
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] x, y;
        int lat, r;
        for (int i = 0; i < 40; i++) begin
            x = WIDTH'($urandom);
            case ($urandom_range(0, 2))
                0: y = WIDTH'($urandom);
                1: y = x;
                default: y = x ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
            endcase
            txn(x, y, 1'b0, lat, r);
            tests++;
            if (lat !== model_lat(x, y) || r !== model_res(x, y)) begin
                fails++; $display("FAIL rand[%0d] a=%h b=%h: lat=%0d res=%0d want %0d %0d", i, x, y, lat, r, model_lat(x, y), model_res(x, y));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] x, y;
        int lat, r;
        for (int i = 0; i < 10; i++) begin
            x = WIDTH'($urandom);
            y = (i % 3 == 0) ? x : WIDTH'($urandom);
            txn(x, y, 1'b1, lat, r);
            tests++;
            if (lat !== model_lat(x, y) || r !== model_res(x, y)) begin
                fails++; $display("FAIL b2b[%0d] a=%h b=%h: lat=%0d res=%0d want %0d %0d", i, x, y, lat, r, model_lat(x, y), model_res(x, y));
            end
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++; $display("FAIL b2b_gap[%0d]: out_valid=%b in_ready=%b want 0 1", i, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        repeat (WIDTH + 3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mid_run();
        test_hold();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
